// File: rtl/pwm_bank_pkg.sv
// Shared register map and CTRL bit positions for the PWM bank.
package pwm_bank_pkg;

  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_PRESCALE = 1;
  localparam int ADDR_PERIOD   = 2;
  localparam int ADDR_DUTY0    = 3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_ONESHOT  = 1;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending/active duty pair, compare against the shared
// counter, and the registered output.
module pwm_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_data_i,
  input  logic             direct_i,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] duty_o,
  output logic             pwm_o
);

  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic             pwm_q, pwm_d;

  // Duty update (a write and a wrap load never share an edge) and compare.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    if (wr_i) begin
      pend_d = wr_data_i;
      if (direct_i) act_d = wr_data_i;
    end
    if (load_i) act_d = pend_q;
    pwm_d = run_i && (cnt_i < act_q);
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      act_q  <= '0;
      pwm_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      pwm_q  <= pwm_d;
    end
  end

  assign duty_o = pend_q;
  assign pwm_o  = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Bank of PWM channels sharing a prescaler and a period counter, with a
// simple valid/ready register write port and a combinational read port.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  logic             en_q, en_d, one_q, one_d;
  logic [CNT_W-1:0] prescale_q, prescale_d;
  logic [CNT_W-1:0] per_pend_q, per_pend_d, per_act_q, per_act_d;
  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d, cnt_q, cnt_d;
  logic             ptick_q, ptick_d;

  logic tick, wrap, wr_fire, ctrl_wr, clr_en, run;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_pend;
  logic [NUM_CH-1:0]            pwm;

  // >= keeps the prescaler bounded if PRESCALE is lowered while running.
  assign tick     = en_q && (pre_cnt_q >= prescale_q);
  assign wrap     = tick && (cnt_q == per_act_q);
  // The wrap edge owns the active copies, so writes are held off then.
  assign wr_ready = !wrap;
  assign wr_fire  = wr_valid && wr_ready;
  assign ctrl_wr  = wr_fire && (wr_addr == ADDR_W'(ADDR_CTRL));
  assign clr_en   = ctrl_wr && !wr_data[CTRL_EN];
  assign run      = en_q && !clr_en;

  // Control/config register next state, including wrap load and one-shot stop.
  always_comb begin
    en_d       = en_q;
    one_d      = one_q;
    prescale_d = prescale_q;
    per_pend_d = per_pend_q;
    per_act_d  = per_act_q;
    if (wrap) begin
      per_act_d = per_pend_q;
      if (one_q) begin
        en_d  = 1'b0;
        one_d = 1'b0;
      end
    end
    if (ctrl_wr) begin
      en_d  = wr_data[CTRL_EN];
      one_d = wr_data[CTRL_ONESHOT];
    end
    if (wr_fire && (wr_addr == ADDR_W'(ADDR_PRESCALE))) prescale_d = wr_data;
    if (wr_fire && (wr_addr == ADDR_W'(ADDR_PERIOD))) begin
      per_pend_d = wr_data;
      if (!en_q) per_act_d = wr_data;
    end
  end

  // Prescaler and period counter; both sit at 0 whenever the bank is stopped.
  always_comb begin
    pre_cnt_d = '0;
    cnt_d     = '0;
    ptick_d   = wrap;
    if (run) begin
      cnt_d = cnt_q;
      if (tick) begin
        pre_cnt_d = '0;
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end
  end

  // Bank state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      one_q      <= 1'b0;
      prescale_q <= '0;
      per_pend_q <= '1;
      per_act_q  <= '1;
      pre_cnt_q  <= '0;
      cnt_q      <= '0;
      ptick_q    <= 1'b0;
    end else begin
      en_q       <= en_d;
      one_q      <= one_d;
      prescale_q <= prescale_d;
      per_pend_q <= per_pend_d;
      per_act_q  <= per_act_d;
      pre_cnt_q  <= pre_cnt_d;
      cnt_q      <= cnt_d;
      ptick_q    <= ptick_d;
    end
  end

  // Read mux: pending copies for PERIOD/DUTY, live bits for CTRL.
  always_comb begin
    rd_data = '0;
    if (rd_addr == ADDR_W'(ADDR_CTRL)) begin
      rd_data[CTRL_EN]      = en_q;
      rd_data[CTRL_ONESHOT] = one_q;
    end else if (rd_addr == ADDR_W'(ADDR_PRESCALE)) begin
      rd_data = prescale_q;
    end else if (rd_addr == ADDR_W'(ADDR_PERIOD)) begin
      rd_data = per_pend_q;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr == ADDR_W'(ADDR_DUTY0 + i)) rd_data = duty_pend[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_i     (wr_fire && (wr_addr == ADDR_W'(ADDR_DUTY0 + g))),
      .wr_data_i(wr_data),
      .direct_i (!en_q),
      .load_i   (wrap),
      .run_i    (run),
      .cnt_i    (cnt_q),
      .duty_o   (duty_pend[g]),
      .pwm_o    (pwm[g])
    );
  end

  assign pwm_out     = pwm;
  assign period_tick = ptick_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: a period-position model runs alongside the DUT and is
// compared every cycle; directed sequences add literal expectations.
module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, wr_ready;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic [3:0] pwm_out;
  logic       period_tick;

  int n_chk = 0;
  int n_pass = 0;

  pwm_bank #(.NUM_CH(4), .CNT_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  // Model: position m_t within the current period, period length
  // (PRESCALE+1)*(PERIOD+1); counter value is m_t / (PRESCALE+1).
  bit       m_en, m_one, m_ptick;
  int       m_pre, m_per_pend, m_per_act, m_t;
  int       m_duty_pend[4], m_duty_act[4];
  bit [3:0] m_pwm;

  task automatic m_reset();
    m_en = 0; m_one = 0; m_ptick = 0; m_pre = 0; m_t = 0;
    m_per_pend = 255; m_per_act = 255; m_pwm = '0;
    for (int i = 0; i < 4; i++) begin m_duty_pend[i] = 0; m_duty_act[i] = 0; end
  endtask

  function automatic bit m_ready();
    int len;
    len = (m_pre + 1) * (m_per_act + 1);
    return !(m_en && (m_t == len - 1));
  endfunction

  function automatic int m_rd(input logic [3:0] a);
    if (a == 4'd0) return {m_one, m_en};
    if (a == 4'd1) return m_pre;
    if (a == 4'd2) return m_per_pend;
    if (a >= 4'd3 && a <= 4'd6) return m_duty_pend[int'(a) - 3];
    return 0;
  endfunction

  task automatic m_step();
    bit wrap, fire, clr, old_en;
    bit [3:0] npwm;
    int len, a;
    len    = (m_pre + 1) * (m_per_act + 1);
    wrap   = m_en && (m_t == len - 1);
    fire   = wr_valid && !wrap;
    a      = int'(wr_addr);
    clr    = fire && a == 0 && !wr_data[0];
    old_en = m_en;
    for (int i = 0; i < 4; i++)
      npwm[i] = m_en && !clr && ((m_t / (m_pre + 1)) < m_duty_act[i]);
    m_ptick = wrap;
    if (wrap) begin
      m_per_act = m_per_pend;
      for (int i = 0; i < 4; i++) m_duty_act[i] = m_duty_pend[i];
      m_t = 0;
      if (m_one) begin m_en = 0; m_one = 0; end
    end else if (m_en) begin
      m_t++;
    end
    if (fire) begin
      if (a == 0) begin m_en = wr_data[0]; m_one = wr_data[1]; end
      else if (a == 1) m_pre = wr_data;
      else if (a == 2) begin m_per_pend = wr_data; if (!old_en) m_per_act = wr_data; end
      else if (a >= 3 && a <= 6) begin
        m_duty_pend[a-3] = wr_data;
        if (!old_en) m_duty_act[a-3] = wr_data;
      end
    end
    if (!m_en || clr) m_t = 0;
    m_pwm = npwm;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("pwm_out", int'(pwm_out), int'(m_pwm));
      chk("period_tick", int'(period_tick), int'(m_ptick));
      chk("wr_ready", int'(wr_ready), int'(m_ready()));
      chk("rd_data", int'(rd_data), m_rd(rd_addr));
    end
  end

  // Called and returns just after a rising edge (+1).
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bit done;
    done = 0;
    wr_valid = 1; wr_addr = a; wr_data = d;
    for (int k = 0; k < 4 && !done; k++) begin
      @(negedge clk);
      done = wr_ready;
      @(posedge clk);
      #1;
    end
    wr_valid = 0;
    if (!done) chk("wr_accept", 0, 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the period_tick cycle; counts channel highs before it.
  task automatic wait_tick(input int ch, output bit ok, output int hi);
    ok = 0; hi = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (period_tick) ok = 1;
      else hi += int'(pwm_out[ch]);
    end
    if (!ok) chk("tick_timeout", 0, 1);
  endtask

  initial begin
    bit ok, prevr;
    int hi, tk, gap, zeros, bad;
    rst_n = 1; wr_valid = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_tick", int'(period_tick), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    rd_addr = 4'd2;
    #1;
    chk("rst_period_rd", int'(rd_data), 255);
    chk("rst_ready", int'(wr_ready), 1);

    // Basic waveform: PERIOD 9, DUTY0 3, no prescale.
    wr(4'd2, 8'd9); wr(4'd3, 8'd3); wr(4'd1, 8'd0); wr(4'd0, 8'd1);
    cycles(5);
    hi = 0; tk = 0;
    repeat (30) begin
      @(negedge clk);
      hi += int'(pwm_out[0]);
      tk += int'(period_tick);
    end
    chk("duty3_highs_30", hi, 9);
    chk("ticks_30", tk, 3);

    // Duty change mid-period takes effect only after the wrap.
    @(posedge clk); #1;
    wr(4'd4, 8'd2);
    wait_tick(1, ok, hi);
    @(posedge clk); #1;
    cycles(3);
    wr(4'd4, 8'd7);
    rd_addr = 4'd4;
    #1;
    chk("duty1_rd_now", int'(rd_data), 7);
    wait_tick(1, ok, hi);
    chk("duty1_old_tail", hi, 0);
    hi = int'(pwm_out[1]);
    repeat (9) begin @(negedge clk); hi += int'(pwm_out[1]); end
    chk("duty1_new_highs", hi, 7);

    // Prescaled period and the wrap-cycle ready drop.
    @(posedge clk); #1;
    wr(4'd0, 8'd0); wr(4'd1, 8'd3); wr(4'd2, 8'd4); wr(4'd0, 8'd1);
    wait_tick(0, ok, hi);
    prevr = wr_ready; zeros = 0; gap = 0;
    for (int k = 1; k <= 60 && gap == 0; k++) begin
      @(negedge clk);
      if (period_tick) gap = k;
      else begin zeros += int'(!wr_ready); prevr = wr_ready; end
    end
    chk("tick_gap", gap, 20);
    chk("ready_before_tick", int'(prevr), 0);
    chk("ready_low_count", zeros, 1);

    // Duty extremes.
    @(posedge clk); #1;
    wr(4'd0, 8'd0); wr(4'd1, 8'd0); wr(4'd2, 8'd9);
    wr(4'd5, 8'd0); wr(4'd6, 8'd255); wr(4'd0, 8'd1);
    cycles(1);
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (pwm_out[2] != 1'b0 || pwm_out[3] != 1'b1) bad++;
    end
    chk("duty_extremes", bad, 0);

    // One-shot.
    @(posedge clk); #1;
    wr(4'd0, 8'd0); wr(4'd2, 8'd4); wr(4'd0, 8'd3);
    tk = 0;
    repeat (30) begin @(negedge clk); tk += int'(period_tick); end
    rd_addr = 4'd0;
    #1;
    chk("oneshot_ticks", tk, 1);
    chk("oneshot_ctrl_rd", int'(rd_data), 0);
    chk("oneshot_pwm", int'(pwm_out), 0);

    // Reset mid-period discards pending PERIOD.
    @(posedge clk); #1;
    wr(4'd0, 8'd1); wr(4'd2, 8'd7);
    chk("pre_rst_pwm0", int'(pwm_out[0]), 1);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_pwm", int'(pwm_out), 0);
    chk("rst_mid_tick", int'(period_tick), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    rd_addr = 4'd2;
    #1;
    chk("rst_mid_period_rd", int'(rd_data), 255);
    @(posedge clk); #1;

    // Disable mid-period: immediate zero, no tick.
    wr(4'd2, 8'd9); wr(4'd3, 8'd9); wr(4'd0, 8'd1);
    cycles(3);
    chk("pre_dis_pwm0", int'(pwm_out[0]), 1);
    wr(4'd0, 8'd0);
    chk("dis_pwm", int'(pwm_out), 0);
    tk = 0;
    repeat (15) begin @(negedge clk); tk += int'(period_tick); end
    chk("dis_no_tick", tk, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
